// File: rtl/mem_dump_ctrl.sv
// End-of-run data memory dump: on request, reads dmem word by word
// and streams each (address, data) pair out over a valid/ready port.
module mem_dump_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  complete,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        OUT,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = done_q;
        unique case (state_q)
            IDLE: begin
                if (complete) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    busy_d    = 1'b1;
                    state_d   = READ;
                end
            end
            READ: begin
                rd_en_d = 1'b0;
                state_d = CAPT;
            end
            CAPT: begin
                data_d  = mem_rd_data;
                addr_d  = rd_addr_q;
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                // Next read is issued only once the current word is taken.
                if (dump_ready) begin
                    valid_d = 1'b0;
                    if (addr_q == LAST_ADDR) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        rd_addr_d = addr_q + ADDR_WIDTH'(1);
                        rd_en_d   = 1'b1;
                        state_d   = READ;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_addr_q;
    assign dump_valid  = valid_q;
    assign dump_addr   = addr_q;
    assign dump_data   = data_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Bench for mem_dump_ctrl: cycle model for a DEPTH=4 instance plus
// word scoreboards for DEPTH=8 (full 3-bit space) and DEPTH=1.
module tb_mem_dump_ctrl;

    localparam int D0 = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        complete, complete1;
    logic        rdy0;
    logic        rdy1 = 1'b1;

    logic        rd_en0, valid0, busy0, done0;
    logic [7:0]  rd_addr0, addr0;
    logic [31:0] rdata0, data0;

    logic        rd_en1, valid1, busy1, done1;
    logic [2:0]  rd_addr1, addr1;
    logic [31:0] rdata1, data1;

    logic        rd_en2, valid2, busy2, done2;
    logic [2:0]  rd_addr2, addr2;
    logic [31:0] rdata2, data2;

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [8];
    logic [31:0] mem2 [8];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int acc_cyc[$];
    int acc_adr[$];
    int cnt1 = 0, cnt2 = 0;
    int last1 = -1, last2 = -1;
    logic stall_mode = 1'b0;
    int stall_cnt = 0;

    mem_dump_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(D0)) u0 (
        .clk(clk), .reset(reset), .complete(complete),
        .mem_rd_en(rd_en0), .mem_rd_addr(rd_addr0), .mem_rd_data(rdata0),
        .dump_valid(valid0), .dump_ready(rdy0), .dump_addr(addr0),
        .dump_data(data0), .busy(busy0), .done(done0)
    );

    mem_dump_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .DEPTH(8)) u1 (
        .clk(clk), .reset(reset), .complete(complete1),
        .mem_rd_en(rd_en1), .mem_rd_addr(rd_addr1), .mem_rd_data(rdata1),
        .dump_valid(valid1), .dump_ready(rdy1), .dump_addr(addr1),
        .dump_data(data1), .busy(busy1), .done(done1)
    );

    mem_dump_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .DEPTH(1)) u2 (
        .clk(clk), .reset(reset), .complete(complete1),
        .mem_rd_en(rd_en2), .mem_rd_addr(rd_addr2), .mem_rd_data(rdata2),
        .dump_valid(valid2), .dump_ready(rdy1), .dump_addr(addr2),
        .dump_data(data2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem0[i] = 32'hA0 + i;
        for (int i = 0; i < 8; i++) mem1[i] = 32'hB000 + 3 * i;
        for (int i = 0; i < 8; i++) mem2[i] = 32'hC0DE + i;
    end

    always @(posedge clk) begin
        if (rd_en0) rdata0 <= mem0[rd_addr0];
        if (rd_en1) rdata1 <= mem1[rd_addr1];
        if (rd_en2) rdata2 <= mem2[rd_addr2];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Abstract model: a word becomes visible two edges after its read
    // is issued, and the next read is issued on the accepting edge.
    logic        m_busy, m_done, m_valid, m_rden;
    int          m_idx, m_wait;
    logic [7:0]  m_rdaddr, m_addr;
    logic [31:0] m_data;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_valid = 0; m_rden = 0;
            m_idx = 0; m_wait = 0; m_rdaddr = 0; m_addr = 0; m_data = 0;
        end else begin
            m_rden = 0;
            if (m_busy) begin
                if (m_valid) begin
                    if (rdy0) begin
                        m_valid = 0;
                        if (m_idx == D0 - 1) begin
                            m_busy = 0;
                            m_done = 1;
                        end else begin
                            m_idx++;
                            m_wait = 2;
                            m_rden = 1;
                            m_rdaddr = 8'(m_idx);
                        end
                    end
                end else begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_valid = 1;
                        m_addr = 8'(m_idx);
                        m_data = 32'hA0 + m_idx;
                    end
                end
            end else if (!m_done && complete) begin
                m_busy = 1;
                m_idx = 0;
                m_wait = 2;
                m_rden = 1;
                m_rdaddr = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("rd_en", 32'(rd_en0), 32'(m_rden));
        chk("rd_addr", 32'(rd_addr0), 32'(m_rdaddr));
        chk("dump_valid", 32'(valid0), 32'(m_valid));
        chk("dump_addr", 32'(addr0), 32'(m_addr));
        chk("dump_data", data0, m_data);
        chk("busy", 32'(busy0), 32'(m_busy));
        chk("done", 32'(done0), 32'(m_done));
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && rd_en0) rd_cnt++;
        if (!reset && valid0 && rdy0) begin
            acc_cyc.push_back(cyc);
            acc_adr.push_back(int'(addr0));
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt1 = 0; cnt2 = 0; last1 = -1; last2 = -1;
        end else begin
            if (valid1 && rdy1) begin
                chk("u1_addr", 32'(addr1), 32'(cnt1));
                chk("u1_data", data1, 32'hB000 + 3 * cnt1);
                last1 = int'(addr1);
                cnt1++;
            end
            if (valid2 && rdy1) begin
                chk("u2_addr", 32'(addr2), 32'(cnt2));
                chk("u2_data", data2, 32'hC0DE + cnt2);
                last2 = int'(addr2);
                cnt2++;
            end
        end
    end

    always @(negedge clk) begin
        if (stall_mode) begin
            if (valid0 && addr0 == 8'd1 && stall_cnt < 5) begin
                rdy0 = 1'b0;
                stall_cnt++;
            end else begin
                rdy0 = 1'b1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        complete = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd_cnt = 0;
        acc_cyc.delete();
        acc_adr.delete();
    endtask

    task automatic wait_done0(input int lim);
        for (int i = 0; i < lim && !done0; i++) @(negedge clk);
        chk("wait_done0", 32'(done0), 32'd1);
    endtask

    int e0;

    initial begin
        reset = 1'b1;
        complete = 1'b0;
        complete1 = 1'b0;
        rdy0 = 1'b1;
        #13;
        chk("rst_valid", 32'(valid0), 32'd0);
        chk("rst_rd_en", 32'(rd_en0), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // idle with no request
        repeat (20) @(negedge clk);
        chk("idle_rd_cnt", 32'(rd_cnt), 32'd0);

        // straight dump, sink always ready
        do_reset();
        @(negedge clk);
        e0 = cyc;
        complete = 1'b1;
        while (cyc < e0 + 12) @(negedge clk);
        chk("t2_done_early", 32'(done0), 32'd0);
        @(negedge clk);
        chk("t2_done", 32'(done0), 32'd1);
        chk("t2_busy", 32'(busy0), 32'd0);
        chk("t2_nacc", 32'(acc_cyc.size()), 32'd4);
        for (int k = 0; k < 4 && k < acc_cyc.size(); k++) begin
            chk("t2_acc_edge", 32'(acc_cyc[k] - e0), 32'(3 * (k + 1)));
            chk("t2_acc_addr", 32'(acc_adr[k]), 32'(k));
        end
        chk("t2_rd_cnt", 32'(rd_cnt), 32'd4);
        complete = 1'b0;

        // five-cycle stall on word 1
        do_reset();
        stall_cnt = 0;
        stall_mode = 1'b1;
        @(negedge clk);
        e0 = cyc;
        complete = 1'b1;
        wait_done0(40);
        stall_mode = 1'b0;
        rdy0 = 1'b1;
        chk("t3_stalls", 32'(stall_cnt), 32'd5);
        chk("t3_nacc", 32'(acc_cyc.size()), 32'd4);
        if (acc_cyc.size() == 4) begin
            chk("t3_acc1", 32'(acc_cyc[1] - e0), 32'd11);
            chk("t3_acc3", 32'(acc_cyc[3] - e0), 32'd17);
        end
        chk("t3_rd_cnt", 32'(rd_cnt), 32'd4);
        complete = 1'b0;

        // one-cycle request pulse, then re-request after done
        do_reset();
        @(negedge clk);
        complete = 1'b1;
        @(negedge clk);
        complete = 1'b0;
        wait_done0(40);
        complete = 1'b1;
        repeat (10) @(negedge clk);
        complete = 1'b0;
        chk("t4_done", 32'(done0), 32'd1);
        chk("t4_rd_cnt", 32'(rd_cnt), 32'd4);
        chk("t4_nacc", 32'(acc_cyc.size()), 32'd4);

        // async reset while word 2 is on offer, then restart
        do_reset();
        rdy0 = 1'b0;
        @(negedge clk);
        complete = 1'b1;
        for (int i = 0; i < 40 && !(valid0 && addr0 == 8'd2); i++) begin
            rdy0 = 1'b1;
            @(negedge clk);
            if (!(valid0 && addr0 == 8'd2)) rdy0 = 1'b1;
        end
        rdy0 = 1'b0;
        chk("t5_reach_w2", 32'(addr0), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_valid", 32'(valid0), 32'd0);
        chk("t5_busy", 32'(busy0), 32'd0);
        chk("t5_addr", 32'(addr0), 32'd0);
        @(negedge clk);
        rdy0 = 1'b1;
        reset = 1'b0;
        rd_cnt = 0;
        acc_cyc.delete();
        acc_adr.delete();
        wait_done0(40);
        chk("t5_nacc", 32'(acc_cyc.size()), 32'd4);
        if (acc_adr.size() > 0) chk("t5_first", 32'(acc_adr[0]), 32'd0);
        complete = 1'b0;

        // DEPTH=8 over a 3-bit address, and DEPTH=1
        do_reset();
        @(negedge clk);
        complete1 = 1'b1;
        for (int i = 0; i < 60 && !(done1 && done2); i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("t6_done8", 32'(done1), 32'd1);
        chk("t6_done1", 32'(done2), 32'd1);
        chk("t6_cnt8", 32'(cnt1), 32'd8);
        chk("t6_cnt1", 32'(cnt2), 32'd1);
        chk("t6_last8", 32'(last1), 32'd7);
        chk("t6_last1", 32'(last2), 32'd0);
        chk("t6_busy8", 32'(busy1), 32'd0);
        complete1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
